// File: rtl/frogger_collision_engine.sv
// frogger_collision_engine: serial per-frame car/frog collision scan with
// lives, respawn handshake and a post-respawn grace window.
//
// Ports:
//   i_Clk, i_Rst          clock, async active-high reset
//   i_Frame_Tick          one pulse per frame, starts a scan
//   i_Frogger_X/Y         frog position (latched on the tick)
//   i_Car_X/Y             packed car positions, car k at [k*COORD_W +: COORD_W]
//   i_Respawn_Ack         frog controller has returned the frog to origin
//   o_Collided            one-cycle hit pulse
//   o_Hit_Index           index of last car hit, held until the next hit
//   o_Respawn_Req         level request, dropped the cycle after the ack
//   o_Lives               remaining lives
//   o_Game_Over           sticky until reset
//   o_Busy                high whenever the engine is not idle
//
// Build option: define FROGGER_GRACE_EN to enable the GRACE window after a
// respawn; without it the engine returns straight to IDLE after the ack.

module frogger_collision_engine #(
    parameter int NUM_CARS     = 5,
    parameter int COORD_W      = 6,
    parameter int CAR_LEN      = 2,
    parameter int LIVES        = 3,
    parameter int GRACE_FRAMES = 30
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic                        i_Frame_Tick,
    input  logic [COORD_W-1:0]          i_Frogger_X,
    input  logic [COORD_W-1:0]          i_Frogger_Y,
    input  logic [NUM_CARS*COORD_W-1:0] i_Car_X,
    input  logic [NUM_CARS*COORD_W-1:0] i_Car_Y,
    input  logic                        i_Respawn_Ack,
    output logic                        o_Collided,
    output logic [5:0]                  o_Hit_Index,
    output logic                        o_Respawn_Req,
    output logic [3:0]                  o_Lives,
    output logic                        o_Game_Over,
    output logic                        o_Busy
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        HIT,
        RESPAWN,
        GRACE,
        OVER
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_CARS - 1);
    localparam logic [7:0] GRACE_LAST = 8'(GRACE_FRAMES - 1);
    localparam logic [COORD_W:0] LEN_M1 = (COORD_W + 1)'(CAR_LEN - 1);

`ifdef FROGGER_GRACE_EN
    localparam state_t ACK_NEXT = GRACE;
`else
    localparam state_t ACK_NEXT = IDLE;
`endif

    state_t             state;
    logic [5:0]         idx;
    logic [7:0]         grace_cnt;
    logic [COORD_W-1:0] frog_x;
    logic [COORD_W-1:0] frog_y;

    logic [COORD_W-1:0] car_x;
    logic [COORD_W-1:0] car_y;
    logic [COORD_W:0]   fx_w;
    logic [COORD_W:0]   cx_w;
    logic [COORD_W:0]   cx_end;
    logic               hit;

    // Car buses are read live; the movers only update on the frame tick.
    assign car_x  = i_Car_X[idx*COORD_W +: COORD_W];
    assign car_y  = i_Car_Y[idx*COORD_W +: COORD_W];

    // One extra bit so a car at the right edge cannot wrap onto column 0.
    assign fx_w   = {1'b0, frog_x};
    assign cx_w   = {1'b0, car_x};
    assign cx_end = cx_w + LEN_M1;
    assign hit    = (car_y == frog_y) && (cx_w <= fx_w) && (fx_w <= cx_end);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state         <= IDLE;
            idx           <= '0;
            grace_cnt     <= '0;
            frog_x        <= '0;
            frog_y        <= '0;
            o_Collided    <= 1'b0;
            o_Hit_Index   <= '0;
            o_Respawn_Req <= 1'b0;
            o_Lives       <= 4'(LIVES);
            o_Game_Over   <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            o_Collided <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Frame_Tick) begin
                        frog_x <= i_Frogger_X;
                        frog_y <= i_Frogger_Y;
                        idx    <= '0;
                        state  <= SCAN;
                        o_Busy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        state       <= HIT;
                        o_Collided  <= 1'b1;
                        o_Hit_Index <= idx;
                        o_Lives     <= o_Lives - 4'd1;
                    end else if (idx == LAST_IDX) begin
                        state  <= IDLE;
                        idx    <= '0;
                        o_Busy <= 1'b0;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                HIT: begin
                    // o_Lives already holds the decremented value here.
                    if (o_Lives == 4'd0) begin
                        state       <= OVER;
                        o_Game_Over <= 1'b1;
                    end else begin
                        state         <= RESPAWN;
                        o_Respawn_Req <= 1'b1;
                    end
                end
                RESPAWN: begin
                    if (i_Respawn_Ack) begin
                        o_Respawn_Req <= 1'b0;
                        grace_cnt     <= '0;
                        state         <= ACK_NEXT;
                        o_Busy        <= (ACK_NEXT != IDLE);
                    end
                end
                GRACE: begin
                    // The closing tick is consumed here, not used to scan.
                    if (i_Frame_Tick) begin
                        if (grace_cnt == GRACE_LAST) begin
                            grace_cnt <= '0;
                            state     <= IDLE;
                            o_Busy    <= 1'b0;
                        end else begin
                            grace_cnt <= grace_cnt + 8'd1;
                        end
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frogger_collision_engine.sv
// tb_frogger_collision_engine: scoreboard bench for the collision engine.
// Expected frame results are queued at stimulus time and checked on output.

module tb_frogger_collision_engine;

    localparam int N  = 5;
    localparam int CW = 6;
    localparam int CL = 2;
    localparam int LV = 3;
    localparam int GF = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick = 1'b0;
    logic            ack = 1'b0;
    logic [CW-1:0]   fx = '0;
    logic [CW-1:0]   fy = '0;
    logic [N*CW-1:0] cxb = '0;
    logic [N*CW-1:0] cyb = '0;

    logic       collided;
    logic [5:0] hit_idx;
    logic       req;
    logic [3:0] lives;
    logic       over;
    logic       busy;

    frogger_collision_engine #(
        .NUM_CARS(N),
        .COORD_W(CW),
        .CAR_LEN(CL),
        .LIVES(LV),
        .GRACE_FRAMES(GF)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Frame_Tick(tick),
        .i_Frogger_X(fx),
        .i_Frogger_Y(fy),
        .i_Car_X(cxb),
        .i_Car_Y(cyb),
        .i_Respawn_Ack(ack),
        .o_Collided(collided),
        .o_Hit_Index(hit_idx),
        .o_Respawn_Req(req),
        .o_Lives(lives),
        .o_Game_Over(over),
        .o_Busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hit;
        int at;
        int idx;
        int lives;
        int busy0;
        int busy_end;
        int req;
        int over;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;

    int cx[N];
    int cy[N];

    int m_lives = LV;
    int m_last  = 0;
    int m_pend  = 0;
    int m_over  = 0;
    int m_grace = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic set_cars();
        for (int k = 0; k < N; k++) begin
            cxb[k*CW +: CW] = CW'(cx[k]);
            cyb[k*CW +: CW] = CW'(cy[k]);
        end
    endtask

    task automatic park();
        for (int k = 0; k < N; k++) begin
            cx[k] = 0;
            cy[k] = 30;
        end
        set_cars();
    endtask

    task automatic model_reset();
        m_lives = LV;
        m_last  = 0;
        m_pend  = 0;
        m_over  = 0;
        m_grace = 0;
    endtask

    task automatic frame(input string tag);
        exp_t e;
        exp_t o;
        int kh;
        int pulses;
        int at;
        int b0;
        kh = -1;
        e.busy0 = 1;
        if (m_over != 0 || m_pend != 0) begin
            kh = -1;
        end else if (m_grace > 0) begin
            m_grace--;
            if (m_grace == 0) e.busy0 = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (kh < 0 && cy[k] == int'(fy) && cx[k] <= int'(fx)
                    && int'(fx) <= cx[k] + CL - 1)
                    kh = k;
            end
            if (kh >= 0) begin
                m_lives--;
                m_last = kh;
                if (m_lives == 0) m_over = 1;
                else m_pend = 1;
            end
        end
        e.hit      = (kh >= 0) ? 1 : 0;
        e.at       = kh;
        e.idx      = m_last;
        e.lives    = m_lives;
        e.req      = m_pend;
        e.over     = m_over;
        e.busy_end = (m_over != 0 || m_pend != 0 || m_grace > 0) ? 1 : 0;
        sb.push_back(e);

        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        b0 = int'(busy);
        pulses = 0;
        at = -1;
        for (int j = 0; j < N + 4; j++) begin
            @(negedge clk);
            if (collided) begin
                pulses++;
                if (at < 0) at = j;
            end
        end

        o = sb.pop_front();
        chk({tag, ".pulses"}, pulses, o.hit);
        chk({tag, ".at"}, at, o.at);
        chk({tag, ".busy0"}, b0, o.busy0);
        chk({tag, ".idx"}, int'(hit_idx), o.idx);
        chk({tag, ".lives"}, int'(lives), o.lives);
        chk({tag, ".req"}, int'(req), o.req);
        chk({tag, ".over"}, int'(over), o.over);
        chk({tag, ".busy"}, int'(busy), o.busy_end);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_pend = 0;
`ifdef FROGGER_GRACE_EN
        m_grace = GF;
`else
        m_grace = 0;
`endif
        chk({tag, ".req"}, int'(req), 0);
        chk({tag, ".busy"}, int'(busy), (m_grace > 0) ? 1 : 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".col"}, int'(collided), 0);
        chk({tag, ".idx"}, int'(hit_idx), 0);
        chk({tag, ".req"}, int'(req), 0);
        chk({tag, ".lives"}, int'(lives), LV);
        chk({tag, ".over"}, int'(over), 0);
        chk({tag, ".busy"}, int'(busy), 0);
    endtask

    task automatic clear_grace();
        park();
        fx = 6'd10;
        fy = 6'd4;
        for (int i = 0; i < GF; i++) frame("clr");
    endtask

    initial begin
        park();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst");

        // Frog just past the car's tail: no hit.
        park();
        cx[2] = 11; cy[2] = 4;
        set_cars();
        fx = 6'd13; fy = 6'd4;
        frame("miss13");

        // Car at the right edge must not alias onto column 0.
        park();
        cx[4] = 63; cy[4] = 4;
        set_cars();
        fx = 6'd0; fy = 6'd4;
        frame("nowrap");

        // Basic hit on car 2.
        park();
        cx[2] = 11; cy[2] = 4;
        set_cars();
        fx = 6'd10; fy = 6'd4;
        frame("car2");
        fx = 6'd11;
        frame("car2");
        do_ack("ack1");
        clear_grace();

        // Async reset in the middle of a scan.
        park();
        cx[3] = 10; cy[3] = 4;
        set_cars();
        fx = 6'd10; fy = 6'd4;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        chk("mid.busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1 chk_reset("mid");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Tail of a car (x=12 over car at 11) on car 0 right after reset.
        park();
        cx[0] = 11; cy[0] = 4;
        set_cars();
        fx = 6'd12; fy = 6'd4;
        frame("tail0");
        do_ack("ack2");

        // Frog stays on the car after respawn.
        for (int i = 0; i < GF + 1; i++) frame("stay");
        if (m_pend != 0) do_ack("ack3");
        clear_grace();

        // Two overlapping cars: lowest index wins, single decrement.
        park();
        cx[1] = 20; cy[1] = 7;
        cx[3] = 19; cy[3] = 7;
        set_cars();
        fx = 6'd20; fy = 6'd7;
        frame("multi");

        // Game over is absorbing.
        frame("over");
        frame("over");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
